route_lock_dispatcher: RTL and testbench
========================================

ROUTE_LOCK_DISPATCHER -- requirements
Module: route_lock_dispatcher

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, TDATA width; ID_WIDTH/DEST_WIDTH/USER_WIDTH, 4, present only under TID/TDEST/TUSER_PRESENT.
REQ-002 Parameters SHALL be: MAX_ROUTERS_X, 4, mesh columns; MAX_ROUTERS_Y, 4, mesh rows; ROUTER_X, 0, own column; ROUTER_Y, 0, own row.
REQ-003 Parameters SHALL be: ROUTING_MODE, 0, 0=XY (X first), 1=YX (Y first); COUNTER_WIDTH, 16, statistics counter width.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low; clk_i input 1 rising-edge clock; rst_n_i input 1 async active-low reset.
REQ-005 in_mosi_i input axis_mosi_t, upstream beat; in_miso_o output axis_miso_t, upstream TREADY.
REQ-006 out_mosi_o output axis_mosi_t[5], per-channel beat; out_miso_i input axis_miso_t[5], per-channel TREADY.
REQ-007 target_x_i input clog2(MAX_ROUTERS_X), target_y_i input clog2(MAX_ROUTERS_Y): destination, sampled only on header beats.
REQ-008 cnt_clear_i input 1, synchronous clear of all counters; out_busy_o output 5, per-channel packet-in-progress.
REQ-009 pkt_cnt_o output COUNTER_WIDTH[5], completed packets per channel; drop_cnt_o output COUNTER_WIDTH, dropped packets.

Function
REQ-010 Channels SHALL be 0=LOCAL, 1=X+, 2=X-, 3=Y+, 4=Y-; LOCAL when target equals (ROUTER_X, ROUTER_Y).
REQ-011 XY mode SHALL correct X first, then Y; YX mode SHALL correct Y first, then X.
REQ-012 FSM states SHALL be IDLE, FORWARD, DROP; reset state IDLE.
REQ-013 Header = TVALID with TID == ROUTING_HEADER; route computed combinationally from target inputs, latched into route_q on header handshake.
REQ-014 Datapath latency SHALL be zero: out_mosi_o[sel] = in_mosi_i, in_miso_o.TREADY = out_miso_i[sel].TREADY; all other out_mosi_o SHALL be all-zero.
REQ-015 sel SHALL be computed route in IDLE, route_q in FORWARD; target inputs SHALL be ignored in FORWARD/DROP.
REQ-016 IDLE, header handshake, TLAST=0 -> FORWARD, out_busy_o[route] <= 1.
REQ-017 IDLE, header handshake, TLAST=1 -> stay IDLE, pkt_cnt_o[route] increments.
REQ-018 FORWARD, handshake with TLAST=1 -> IDLE, out_busy_o cleared, pkt_cnt_o[route_q] increments; header-TID beats in FORWARD SHALL be forwarded as data.
REQ-019 IDLE header with target_x_i >= MAX_ROUTERS_X or target_y_i >= MAX_ROUTERS_Y SHALL be discarded: in_miso_o.TREADY=1, no output TVALID, -> DROP (or stay IDLE and count if TLAST=1).
REQ-020 DROP SHALL accept and discard every beat (TREADY=1) until TLAST handshake -> IDLE, drop_cnt_o increments.
REQ-021 IDLE non-header beat SHALL be discarded (TREADY=1), counted in drop_cnt_o on its TLAST, FSM -> DROP if TLAST=0.
REQ-022 TVALID low or TREADY low SHALL hold state; no state change without handshake.
REQ-023 pkt_cnt_o SHALL wrap from all-ones to 0; drop_cnt_o SHALL saturate at all-ones.
REQ-024 cnt_clear_i coincident with an increment SHALL yield 0 (clear wins); FSM and route_q unaffected.

Reset
REQ-025 rst_n_i low SHALL asynchronously force state IDLE, route_q 0, out_busy_o 0, all counters 0.
REQ-026 During reset, in_miso_o.TREADY SHALL follow out_miso_i[computed route]; reset mid-packet SHALL abandon the packet with no count.

Structure
REQ-027 ROUTING_HEADER, channel index localparams, FSM state enum and ROUTING_MODE encodings SHALL live in the shared router package; axis_mosi_t/axis_miso_t from the shared AXIS type include.
REQ-028 One sub-module route_compute (pure combinational, parameters ROUTER_X/Y, MAX_ROUTERS_X/Y, ROUTING_MODE) SHALL produce channel index and out-of-range flag.

Verification
REQ-029 Router (1,1), XY, 4x4: header target (3,0), 3 beats, last TLAST, all TREADY=1 -> all beats on channel 1, pkt_cnt_o[1]=1, out_busy_o[1] high during beats 2-3 only.
REQ-030 Same router, YX: header target (3,0) -> channel 4; target changed to (1,1) mid-packet -> remaining beats stay on channel 4.
REQ-031 Header target (1,1), TLAST=1, out_miso_i[0].TREADY low 3 cycles -> beat held on channel 0, in_miso_o.TREADY low 3 cycles, pkt_cnt_o[0]=1 after acceptance.
REQ-032 MAX_ROUTERS_X=3, header target (3,0) + 2 beats -> no output TVALID, TREADY=1, drop_cnt_o=1; then valid packet routes normally.
REQ-033 COUNTER_WIDTH=4: 17 single-beat packets to LOCAL -> pkt_cnt_o[0]=1; cnt_clear_i with 18th packet's handshake -> 0.
REQ-034 rst_n_i pulsed low mid-FORWARD -> state IDLE, out_busy_o=0, counters 0 immediately, next header routed fresh.

Source files
------------

// File: rtl/route_lock_dispatcher_pkg.sv
// Shared router definitions: AXI-Stream beat types, channel indices,
// routing-mode encodings and the dispatcher FSM state type.
package route_lock_dispatcher_pkg;

    // Physical AXI-Stream field widths carried by the beat structs.
    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_ID_W   = 4;
    localparam int AXIS_DEST_W = 4;
    localparam int AXIS_USER_W = 4;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_ID_W-1:0]   tid;
        logic [AXIS_DEST_W-1:0] tdest;
        logic [AXIS_USER_W-1:0] tuser;
        logic                   tlast;
        logic                   tvalid;
    } axis_mosi_t;

    typedef struct packed {
        logic tready;
    } axis_miso_t;

    // A beat whose TID carries this value opens a packet and selects its route.
    localparam logic [AXIS_ID_W-1:0] ROUTING_HEADER = 4'hF;

    // Output channels.
    localparam int NUM_CH = 5;
    localparam int CH_W   = 3;
    localparam logic [CH_W-1:0] CH_LOCAL  = 3'd0;
    localparam logic [CH_W-1:0] CH_X_PLUS = 3'd1;
    localparam logic [CH_W-1:0] CH_X_MIN  = 3'd2;
    localparam logic [CH_W-1:0] CH_Y_PLUS = 3'd3;
    localparam logic [CH_W-1:0] CH_Y_MIN  = 3'd4;

    // Dimension-order routing modes.
    localparam int ROUTE_MODE_XY = 0;
    localparam int ROUTE_MODE_YX = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    // Coordinate port width: at least one bit even for a single-router dimension.
    function automatic int coord_w(input int max_routers);
        return (max_routers > 1) ? $clog2(max_routers) : 1;
    endfunction

endpackage

// File: rtl/route_lock_dispatcher_if.sv
// Stream bundle between an upstream source, the dispatcher and its five
// output channels.
//
// Handshake: a beat transfers on a rising clock edge where TVALID and TREADY
// are both high. A source holds its beat stable while TVALID is high and
// TREADY is low; TREADY may depend combinationally on TVALID and on the
// downstream TREADY of the selected channel.
interface route_lock_dispatcher_if;
    import route_lock_dispatcher_pkg::*;

    axis_mosi_t              in_mosi;
    axis_miso_t              in_miso;
    axis_mosi_t [NUM_CH-1:0] out_mosi;
    axis_miso_t [NUM_CH-1:0] out_miso;

    // Environment side: drives the upstream beat and the downstream readies.
    modport master (
        output in_mosi,
        input  in_miso,
        input  out_mosi,
        output out_miso
    );

    // Dispatcher side.
    modport slave (
        input  in_mosi,
        output in_miso,
        output out_mosi,
        input  out_miso
    );
endinterface

// File: rtl/route_lock_dispatcher_route_compute.sv
// Dimension-order route selection for one mesh router: turns a target
// coordinate into an output channel index and flags coordinates that lie
// outside the mesh.
module route_compute
    import route_lock_dispatcher_pkg::*;
#(
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int ROUTING_MODE  = ROUTE_MODE_XY,
    localparam int X_W = coord_w(MAX_ROUTERS_X),
    localparam int Y_W = coord_w(MAX_ROUTERS_Y)
) (
    input  logic [X_W-1:0]  target_x_i,
    input  logic [Y_W-1:0]  target_y_i,
    output logic [CH_W-1:0] route_o,
    output logic            oor_o
);

    logic [31:0]     tx;
    logic [31:0]     ty;
    logic            x_need;
    logic            y_need;
    logic [CH_W-1:0] x_ch;
    logic [CH_W-1:0] y_ch;

    // Per-dimension direction, then pick the dimension that is corrected first.
    always_comb begin
        tx     = 32'(target_x_i);
        ty     = 32'(target_y_i);
        oor_o  = (tx >= 32'(MAX_ROUTERS_X)) || (ty >= 32'(MAX_ROUTERS_Y));
        x_need = (tx != 32'(ROUTER_X));
        y_need = (ty != 32'(ROUTER_Y));
        x_ch   = (tx > 32'(ROUTER_X)) ? CH_X_PLUS : CH_X_MIN;
        y_ch   = (ty > 32'(ROUTER_Y)) ? CH_Y_PLUS : CH_Y_MIN;
        route_o = CH_LOCAL;
        if (ROUTING_MODE == ROUTE_MODE_YX) begin
            if (y_need)      route_o = y_ch;
            else if (x_need) route_o = x_ch;
        end else begin
            if (x_need)      route_o = x_ch;
            else if (y_need) route_o = y_ch;
        end
    end

endmodule

// File: rtl/route_lock_dispatcher.sv
// Route-locking packet dispatcher: the header beat of each packet picks one
// of five output channels, and every following beat of that packet follows
// the same channel until TLAST. Packets with a bad header are swallowed and
// counted as drops.
module route_lock_dispatcher
    import route_lock_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter bit TID_PRESENT   = 1'b1,
    parameter bit TDEST_PRESENT = 1'b1,
    parameter bit TUSER_PRESENT = 1'b1,
    parameter int ID_WIDTH      = 4,
    parameter int DEST_WIDTH    = 4,
    parameter int USER_WIDTH    = 4,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int ROUTING_MODE  = ROUTE_MODE_XY,
    parameter int COUNTER_WIDTH = 16,
    localparam int X_W = coord_w(MAX_ROUTERS_X),
    localparam int Y_W = coord_w(MAX_ROUTERS_Y)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    route_lock_dispatcher_if.slave                axis,
    input  logic [X_W-1:0]                        target_x_i,
    input  logic [Y_W-1:0]                        target_y_i,
    input  logic                                  cnt_clear_i,
    output logic [NUM_CH-1:0]                     out_busy_o,
    output logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]  pkt_cnt_o,
    output logic [COUNTER_WIDTH-1:0]              drop_cnt_o,
    output state_t                                state_o
);

    // Fields narrower than the physical bus are forwarded with upper bits zeroed.
    localparam logic [AXIS_DATA_W-1:0] DATA_MASK =
        AXIS_DATA_W'({AXIS_DATA_W{1'b1}} >> (AXIS_DATA_W - DATA_WIDTH));
    localparam logic [AXIS_ID_W-1:0] ID_MASK = TID_PRESENT ?
        AXIS_ID_W'({AXIS_ID_W{1'b1}} >> (AXIS_ID_W - ID_WIDTH)) : '0;
    localparam logic [AXIS_DEST_W-1:0] DEST_MASK = TDEST_PRESENT ?
        AXIS_DEST_W'({AXIS_DEST_W{1'b1}} >> (AXIS_DEST_W - DEST_WIDTH)) : '0;
    localparam logic [AXIS_USER_W-1:0] USER_MASK = TUSER_PRESENT ?
        AXIS_USER_W'({AXIS_USER_W{1'b1}} >> (AXIS_USER_W - USER_WIDTH)) : '0;

    state_t          state_q;
    state_t          state_d;
    logic [CH_W-1:0] route_q;
    logic [CH_W-1:0] route_d;
    logic [CH_W-1:0] route_ch;
    logic            route_oor;
    logic [CH_W-1:0] sel;
    logic            is_hdr;
    logic            discard;
    logic            ready;
    logic            hs;
    logic            pkt_inc;
    logic [CH_W-1:0] pkt_ch;
    logic            drop_inc;
    axis_mosi_t      fwd_beat;

    route_compute #(
        .MAX_ROUTERS_X (MAX_ROUTERS_X),
        .MAX_ROUTERS_Y (MAX_ROUTERS_Y),
        .ROUTER_X      (ROUTER_X),
        .ROUTER_Y      (ROUTER_Y),
        .ROUTING_MODE  (ROUTING_MODE)
    ) u_route_compute (
        .target_x_i (target_x_i),
        .target_y_i (target_y_i),
        .route_o    (route_ch),
        .oor_o      (route_oor)
    );

    // Channel select, discard decision, upstream ready and next-state logic.
    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        pkt_inc  = 1'b0;
        pkt_ch   = route_q;
        drop_inc = 1'b0;
        ready    = 1'b0;

        is_hdr = axis.in_mosi.tvalid && (axis.in_mosi.tid == ROUTING_HEADER);
        sel    = (state_q == ST_FORWARD) ? route_q : route_ch;
        // While reset is held the port stays a plain pass-through on the
        // computed route, so no beat is swallowed by a half-reset FSM.
        discard = rst_n_i &&
                  ((state_q == ST_DROP) ||
                   ((state_q == ST_IDLE) && axis.in_mosi.tvalid && (!is_hdr || route_oor)));

        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == CH_W'(i)) ready = axis.out_miso[i].tready;
        end
        if (discard) ready = 1'b1;
        hs = axis.in_mosi.tvalid && ready;

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    if (discard) begin
                        if (axis.in_mosi.tlast) drop_inc = 1'b1;
                        else                    state_d  = ST_DROP;
                    end else begin
                        route_d = route_ch;
                        if (axis.in_mosi.tlast) begin
                            pkt_inc = 1'b1;
                            pkt_ch  = route_ch;
                        end else begin
                            state_d = ST_FORWARD;
                        end
                    end
                end
            end
            ST_FORWARD: begin
                if (hs && axis.in_mosi.tlast) begin
                    state_d = ST_IDLE;
                    pkt_inc = 1'b1;
                end
            end
            ST_DROP: begin
                if (hs && axis.in_mosi.tlast) begin
                    state_d  = ST_IDLE;
                    drop_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Zero-latency beat steering: only the selected channel sees the beat.
    always_comb begin
        fwd_beat       = axis.in_mosi;
        fwd_beat.tdata = axis.in_mosi.tdata & DATA_MASK;
        fwd_beat.tid   = axis.in_mosi.tid & ID_MASK;
        fwd_beat.tdest = axis.in_mosi.tdest & DEST_MASK;
        fwd_beat.tuser = axis.in_mosi.tuser & USER_MASK;
        axis.in_miso.tready = ready;
        for (int i = 0; i < NUM_CH; i++) begin
            axis.out_mosi[i] = '0;
            if (!discard && (sel == CH_W'(i))) axis.out_mosi[i] = fwd_beat;
            out_busy_o[i] = (state_q == ST_FORWARD) && (route_q == CH_W'(i));
        end
        state_o = state_q;
    end

    // FSM state and locked route.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            route_q <= CH_LOCAL;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    // Statistics: packet counters wrap, drop counter saturates, clear wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_cnt_o  <= '0;
            drop_cnt_o <= '0;
        end else if (cnt_clear_i) begin
            pkt_cnt_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pkt_inc && (pkt_ch == CH_W'(i))) pkt_cnt_o[i] <= pkt_cnt_o[i] + 1'b1;
            end
            if (drop_inc && (drop_cnt_o != {COUNTER_WIDTH{1'b1}})) drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_route_lock_dispatcher.sv
// Directed bench for route_lock_dispatcher. Three dispatchers at router
// (1,1) share one stimulus stream: A is XY in a 4x4 mesh with 4-bit
// counters, B is YX in a 4x4 mesh, C is XY in a 3-column mesh.
module tb_route_lock_dispatcher;
    import route_lock_dispatcher_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    cnt_clear;
    logic [1:0]              target_x;
    logic [1:0]              target_y;
    axis_mosi_t              in_mosi;
    axis_miso_t [NUM_CH-1:0] out_miso;

    logic [4:0]       busy_a, busy_b, busy_c;
    logic [4:0][3:0]  pkt_a;
    logic [4:0][15:0] pkt_b, pkt_c;
    logic [3:0]       drop_a;
    logic [15:0]      drop_b, drop_c;
    state_t           state_a, state_b, state_c;
    logic [4:0]       tv_a, tv_b, tv_c, nz_a, nz_c;

    int tests_run;
    int tests_failed;

    route_lock_dispatcher_if bus_a ();
    route_lock_dispatcher_if bus_b ();
    route_lock_dispatcher_if bus_c ();

    assign bus_a.in_mosi  = in_mosi;
    assign bus_b.in_mosi  = in_mosi;
    assign bus_c.in_mosi  = in_mosi;
    assign bus_a.out_miso = out_miso;
    assign bus_b.out_miso = out_miso;
    assign bus_c.out_miso = out_miso;

    route_lock_dispatcher #(
        .MAX_ROUTERS_X (4), .MAX_ROUTERS_Y (4), .ROUTER_X (1), .ROUTER_Y (1),
        .ROUTING_MODE (ROUTE_MODE_XY), .COUNTER_WIDTH (4)
    ) u_dut_a (
        .clk_i (clk), .rst_n_i (rst_n), .axis (bus_a),
        .target_x_i (target_x), .target_y_i (target_y), .cnt_clear_i (cnt_clear),
        .out_busy_o (busy_a), .pkt_cnt_o (pkt_a), .drop_cnt_o (drop_a), .state_o (state_a)
    );

    route_lock_dispatcher #(
        .MAX_ROUTERS_X (4), .MAX_ROUTERS_Y (4), .ROUTER_X (1), .ROUTER_Y (1),
        .ROUTING_MODE (ROUTE_MODE_YX), .COUNTER_WIDTH (16)
    ) u_dut_b (
        .clk_i (clk), .rst_n_i (rst_n), .axis (bus_b),
        .target_x_i (target_x), .target_y_i (target_y), .cnt_clear_i (cnt_clear),
        .out_busy_o (busy_b), .pkt_cnt_o (pkt_b), .drop_cnt_o (drop_b), .state_o (state_b)
    );

    route_lock_dispatcher #(
        .MAX_ROUTERS_X (3), .MAX_ROUTERS_Y (4), .ROUTER_X (1), .ROUTER_Y (1),
        .ROUTING_MODE (ROUTE_MODE_XY), .COUNTER_WIDTH (16)
    ) u_dut_c (
        .clk_i (clk), .rst_n_i (rst_n), .axis (bus_c),
        .target_x_i (target_x), .target_y_i (target_y), .cnt_clear_i (cnt_clear),
        .out_busy_o (busy_c), .pkt_cnt_o (pkt_c), .drop_cnt_o (drop_c), .state_o (state_c)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel TVALID and any-bit-set views of the output lanes.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tv_a[i] = bus_a.out_mosi[i].tvalid;
            tv_b[i] = bus_b.out_mosi[i].tvalid;
            tv_c[i] = bus_c.out_mosi[i].tvalid;
            nz_a[i] = |bus_a.out_mosi[i];
            nz_c[i] = |bus_c.out_mosi[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] id,
                         input logic last, input logic [1:0] tx, input logic [1:0] ty);
        in_mosi        = '0;
        in_mosi.tvalid = v;
        in_mosi.tdata  = d;
        in_mosi.tid    = id;
        in_mosi.tlast  = last;
        target_x       = tx;
        target_y       = ty;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        cnt_clear    = 1'b0;
        out_miso     = '1;
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        tick();
        tick();

        // Reset state.
        check("rst_state_a", 32'(state_a), 32'(ST_IDLE));
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_pkt_a", 32'(pkt_a), 32'h0);
        check("rst_drop_c", 32'(drop_c), 32'h0);
        rst_n = 1'b1;
        tick();

        // Three-beat packet to (3,0): A -> X+, B -> Y-, C -> out of range.
        drive(1'b1, 32'hA000_0001, ROUTING_HEADER, 1'b0, 2'd3, 2'd0);
        check("b1_tv_a", 32'(tv_a), 32'h02);
        check("b1_nz_a", 32'(nz_a), 32'h02);
        check("b1_data_a", bus_a.out_mosi[1].tdata, 32'hA000_0001);
        check("b1_tv_b", 32'(tv_b), 32'h10);
        check("b1_tv_c", 32'(tv_c), 32'h00);
        check("b1_nz_c", 32'(nz_c), 32'h00);
        check("b1_rdy_c", 32'(bus_c.in_miso.tready), 32'h1);
        check("b1_busy_a", 32'(busy_a), 32'h00);
        tick();
        check("fwd_state_a", 32'(state_a), 32'(ST_FORWARD));
        check("drop_state_c", 32'(state_c), 32'(ST_DROP));
        // Second beat carries a header TID and a new target: both ignored.
        drive(1'b1, 32'hA000_0002, ROUTING_HEADER, 1'b0, 2'd1, 2'd1);
        check("b2_tv_a", 32'(tv_a), 32'h02);
        check("b2_data_a", bus_a.out_mosi[1].tdata, 32'hA000_0002);
        check("b2_tv_b", 32'(tv_b), 32'h10);
        check("b2_busy_a", 32'(busy_a), 32'h02);
        check("b2_busy_b", 32'(busy_b), 32'h10);
        check("b2_tv_c", 32'(tv_c), 32'h00);
        tick();
        drive(1'b1, 32'hA000_0003, 4'h0, 1'b1, 2'd1, 2'd1);
        check("b3_tv_a", 32'(tv_a), 32'h02);
        check("b3_tv_b", 32'(tv_b), 32'h10);
        check("b3_busy_a", 32'(busy_a), 32'h02);
        tick();
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        check("p1_state_a", 32'(state_a), 32'(ST_IDLE));
        check("p1_busy_a", 32'(busy_a), 32'h00);
        check("p1_pkt_a1", 32'(pkt_a[1]), 32'h1);
        check("p1_pkt_b4", 32'(pkt_b[4]), 32'h1);
        check("p1_drop_c", 32'(drop_c), 32'h1);
        check("p1_pkt_c1", 32'(pkt_c[1]), 32'h0);
        check("p1_state_c", 32'(state_c), 32'(ST_IDLE));

        // Valid packet to (2,1) after the drop: all three route X+.
        drive(1'b1, 32'hB000_0001, ROUTING_HEADER, 1'b0, 2'd2, 2'd1);
        check("p2_tv_c", 32'(tv_c), 32'h02);
        check("p2_tv_b", 32'(tv_b), 32'h02);
        tick();
        drive(1'b1, 32'hB000_0002, 4'h0, 1'b1, 2'd2, 2'd1);
        check("p2_data_c", bus_c.out_mosi[1].tdata, 32'hB000_0002);
        tick();
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        check("p2_pkt_c1", 32'(pkt_c[1]), 32'h1);
        check("p2_drop_c", 32'(drop_c), 32'h1);
        check("p2_pkt_a1", 32'(pkt_a[1]), 32'h2);

        // Non-header first beat: whole packet discarded, header TID inside ignored.
        drive(1'b1, 32'hC000_0001, 4'h3, 1'b0, 2'd0, 2'd0);
        check("p3_nz_a", 32'(nz_a), 32'h00);
        check("p3_rdy_a", 32'(bus_a.in_miso.tready), 32'h1);
        tick();
        check("p3_state_a", 32'(state_a), 32'(ST_DROP));
        drive(1'b1, 32'hC000_0002, ROUTING_HEADER, 1'b1, 2'd0, 2'd0);
        check("p3_tv_a", 32'(tv_a), 32'h00);
        tick();
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        check("p3_drop_a", 32'(drop_a), 32'h1);
        check("p3_drop_c", 32'(drop_c), 32'h2);
        check("p3_state_a2", 32'(state_a), 32'(ST_IDLE));

        // Single-beat LOCAL packet held by downstream backpressure.
        out_miso[0].tready = 1'b0;
        drive(1'b1, 32'hD000_0001, ROUTING_HEADER, 1'b1, 2'd1, 2'd1);
        for (int k = 0; k < 3; k++) begin
            check("p4_stall_tv_a", 32'(tv_a), 32'h01);
            check("p4_stall_rdy_a", 32'(bus_a.in_miso.tready), 32'h0);
            tick();
        end
        check("p4_stall_pkt_a0", 32'(pkt_a[0]), 32'h0);
        check("p4_stall_data_a", bus_a.out_mosi[0].tdata, 32'hD000_0001);
        out_miso[0].tready = 1'b1;
        #1;
        check("p4_rdy_a", 32'(bus_a.in_miso.tready), 32'h1);
        tick();
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        check("p4_pkt_a0", 32'(pkt_a[0]), 32'h1);
        check("p4_pkt_c0", 32'(pkt_c[0]), 32'h1);

        // Asynchronous reset in the middle of a forwarded packet.
        drive(1'b1, 32'hE000_0001, ROUTING_HEADER, 1'b0, 2'd3, 2'd0);
        tick();
        check("p5_fwd_a", 32'(state_a), 32'(ST_FORWARD));
        check("p5_busy_a", 32'(busy_a), 32'h02);
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        rst_n = 1'b0;
        #1;
        check("p5_rst_state_a", 32'(state_a), 32'(ST_IDLE));
        check("p5_rst_busy_a", 32'(busy_a), 32'h00);
        check("p5_rst_pkt_a", 32'(pkt_a), 32'h0);
        check("p5_rst_drop_c", 32'(drop_c), 32'h0);
        // During reset, upstream ready follows the computed route (X- for (0,1)).
        out_miso[2].tready = 1'b0;
        drive(1'b1, 32'hE000_0002, ROUTING_HEADER, 1'b1, 2'd0, 2'd1);
        check("p5_rst_rdy_a", 32'(bus_a.in_miso.tready), 32'h0);
        out_miso[2].tready = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 32'hE000_0003, ROUTING_HEADER, 1'b1, 2'd0, 2'd1);
        check("p5_tv_a", 32'(tv_a), 32'h04);
        tick();
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        check("p5_pkt_a2", 32'(pkt_a[2]), 32'h1);
        check("p5_pkt_a1", 32'(pkt_a[1]), 32'h0);

        // Packet counter wrap: 17 LOCAL packets on a 4-bit counter.
        for (int n = 0; n < 17; n++) begin
            drive(1'b1, 32'(n), ROUTING_HEADER, 1'b1, 2'd1, 2'd1);
            tick();
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        check("p6_wrap_a0", 32'(pkt_a[0]), 32'h1);
        check("p6_cnt_b0", 32'(pkt_b[0]), 32'd17);
        // Clear coincident with the 18th packet's handshake wins.
        drive(1'b1, 32'h0000_0018, ROUTING_HEADER, 1'b1, 2'd1, 2'd1);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0);
        check("p6_clr_pkt_a", 32'(pkt_a), 32'h0);
        check("p6_clr_pkt_b0", 32'(pkt_b[0]), 32'h0);
        check("p6_clr_state_a", 32'(state_a), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
